// File: rtl/cordic_range_reduce.sv
// Reduces a Q8.24 angle to [-pi/2, pi/2] in Q2.30 for a CORDIC core.
// Repeated 2*pi corrections are followed by a single pi fold that flags a cos/sin negation.
module cordic_range_reduce #(
  parameter logic [31:0] PI      = 32'h03243F6B,
  parameter logic [31:0] TWO_PI  = 32'h06487ED6,
  parameter logic [31:0] HALF_PI = 32'h01921FB5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_theta,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_theta,
  output logic        out_negate,
  output logic [4:0]  out_wraps
);

  typedef enum logic [1:0] {IDLE, WRAP, FOLD, OUT} state_t;

  localparam logic signed [32:0] PI_X      = $signed({1'b0, PI});
  localparam logic signed [32:0] TWO_PI_X  = $signed({1'b0, TWO_PI});
  localparam logic signed [32:0] HALF_PI_X = $signed({1'b0, HALF_PI});

  state_t             state_reg;
  logic signed [32:0] acc_reg;
  logic [4:0]         wraps_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic [31:0]        out_theta_reg;
  logic               out_negate_reg;
  logic [4:0]         out_wraps_reg;

  logic signed [32:0] fold_acc_next;
  logic               fold_negate_next;

  // Fold into the right half-plane; the boundaries +/-pi/2 are left untouched.
  always_comb begin
    fold_acc_next    = acc_reg;
    fold_negate_next = 1'b0;
    if (acc_reg > HALF_PI_X) begin
      fold_acc_next    = acc_reg - PI_X;
      fold_negate_next = 1'b1;
    end else if (acc_reg < -HALF_PI_X) begin
      fold_acc_next    = acc_reg + PI_X;
      fold_negate_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      acc_reg        <= '0;
      wraps_reg      <= '0;
      in_ready_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_theta_reg  <= '0;
      out_negate_reg <= 1'b0;
      out_wraps_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            acc_reg      <= {in_theta[31], in_theta};
            wraps_reg    <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= WRAP;
          end else begin
            in_ready_reg <= 1'b1;
          end
        end
        WRAP: begin
          // One correction per cycle; -pi maps to +pi so the result lies in (-pi, pi].
          if (acc_reg > PI_X) begin
            acc_reg   <= acc_reg - TWO_PI_X;
            wraps_reg <= wraps_reg + 5'd1;
          end else if (acc_reg <= -PI_X) begin
            acc_reg   <= acc_reg + TWO_PI_X;
            wraps_reg <= wraps_reg + 5'd1;
          end else begin
            state_reg <= FOLD;
          end
        end
        FOLD: begin
          acc_reg        <= fold_acc_next;
          out_theta_reg  <= {fold_acc_next[25:0], 6'b0};
          out_negate_reg <= fold_negate_next;
          out_wraps_reg  <= wraps_reg;
          out_valid_reg  <= 1'b1;
          state_reg      <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign out_theta  = out_theta_reg;
  assign out_negate = out_negate_reg;
  assign out_wraps  = out_wraps_reg;

endmodule

// File: tb/tb_cordic_range_reduce.sv
// Directed bench for cordic_range_reduce: scoreboard of expected results, checked on out_valid.
module tb_cordic_range_reduce;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_theta = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_theta;
  logic        out_negate;
  logic [4:0]  out_wraps;

  localparam logic signed [32:0] PI_Q   = 33'sh003243F6B;
  localparam logic signed [32:0] TWO_Q  = 33'sh006487ED6;
  localparam logic signed [32:0] HALF_Q = 33'sh001921FB5;

  typedef struct {
    logic [31:0] theta;
    logic        neg;
    logic [4:0]  wraps;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  cordic_range_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_theta  (in_theta),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_theta (out_theta),
    .out_negate(out_negate),
    .out_wraps (out_wraps)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d (%h) expected=%0d (%h)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Reference reduction written straight from the angle rules.
  function automatic exp_t model(input logic [31:0] theta);
    exp_t e;
    logic signed [32:0] a;
    a = {theta[31], theta};
    e.wraps = '0;
    while (a > PI_Q || a <= -PI_Q) begin
      if (a > PI_Q) a = a - TWO_Q;
      else          a = a + TWO_Q;
      e.wraps = e.wraps + 5'd1;
    end
    e.neg = 1'b1;
    if (a > HALF_Q)       a = a - PI_Q;
    else if (a < -HALF_Q) a = a + PI_Q;
    else                  e.neg = 1'b0;
    e.theta = {a[25:0], 6'b0};
    e.lat = int'(e.wraps) + 2;
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] th, input logic ng, input logic [4:0] w);
    exp_t e;
    e.theta = th;
    e.neg = ng;
    e.wraps = w;
    e.lat = int'(w) + 2;
    return e;
  endfunction

  // Transfer one angle, wait for the result and score it; leaves out_valid pending.
  task automatic send(input string tag, input logic [31:0] theta, input exp_t e, input bit hold);
    int n;
    exp_t got;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_theta = theta;
    @(posedge clk);
    sb.push_back(e);
    #1;
    if (hold) in_theta = 32'h7FFF_FFFF;
    else      in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    got = sb.pop_front();
    check({tag, "_theta"}, out_theta, got.theta);
    check({tag, "_negate"}, {31'b0, out_negate}, {31'b0, got.neg});
    check({tag, "_wraps"}, {27'b0, out_wraps}, {27'b0, got.wraps});
    check({tag, "_latency"}, n, got.lat);
    $display("[TB] %s theta_in=%h out_theta=%0d negate=%0b wraps=%0d latency=%0d",
             tag, theta, $signed(out_theta), out_negate, out_wraps, n);
  endtask

  task automatic finish_handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check({tag, "_hs_valid_drop"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_hs_ready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] th;
    logic [31:0] hold_theta;
    logic        hold_neg;
    logic [4:0]  hold_wraps;
    int          seen;

    // Reset state
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_theta", out_theta, 32'd0);
    check("rst_out_negate", {31'b0, out_negate}, 32'd0);
    check("rst_out_wraps", {27'b0, out_wraps}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rel_in_ready_before_clk", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("rel_in_ready_after_clk", {31'b0, in_ready}, 32'd1);

    // Directed vectors with hand-derived results
    send("zero", 32'h0000_0000, mk(32'd0, 1'b0, 5'd0), 1'b0);
    finish_handshake("zero");
    send("three", 32'h0300_0000, mk(-32'sd152033984, 1'b1, 5'd0), 1'b0);
    finish_handshake("three");
    send("sixtyfour", 32'h4000_0000, mk(32'd1254287616, 1'b0, 5'd10), 1'b0);
    finish_handshake("sixtyfour");
    send("neg_pi", -32'h0324_3F6B, mk(32'd0, 1'b1, 5'd1), 1'b0);
    finish_handshake("neg_pi");
    send("pos_pi", 32'h0324_3F6B, mk(32'd0, 1'b1, 5'd0), 1'b0);
    finish_handshake("pos_pi");
    send("half_pi", 32'h0192_1FB5, mk(32'd1686629696, 1'b0, 5'd0), 1'b0);
    finish_handshake("half_pi");
    send("neg_half_pi", -32'h0192_1FB5, mk(-32'sd1686629696, 1'b0, 5'd0), 1'b0);
    finish_handshake("neg_half_pi");
    send("max_pos", 32'h7FFF_FFFF, mk(-32'sd864684288, 1'b1, 5'd20), 1'b0);
    finish_handshake("max_pos");

    // A few random angles against the reference reduction
    for (int i = 0; i < 4; i++) begin
      th = $urandom;
      send($sformatf("rand%0d", i), th, model(th), 1'b0);
      finish_handshake($sformatf("rand%0d", i));
    end

    // Backpressure with in_valid held high and a different angle on the bus
    send("bp", 32'h0300_0000, mk(-32'sd152033984, 1'b1, 5'd0), 1'b1);
    hold_theta = out_theta;
    hold_neg   = out_negate;
    hold_wraps = out_wraps;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_c%0d_valid", c), {31'b0, out_valid}, 32'd1);
      check($sformatf("bp_c%0d_in_ready", c), {31'b0, in_ready}, 32'd0);
      check($sformatf("bp_c%0d_theta", c), out_theta, hold_theta);
      check($sformatf("bp_c%0d_negate", c), {31'b0, out_negate}, {31'b0, hold_neg});
      check($sformatf("bp_c%0d_wraps", c), {27'b0, out_wraps}, {27'b0, hold_wraps});
    end
    finish_handshake("bp");

    // Reset in the middle of WRAP discards the angle
    in_valid = 1'b1;
    in_theta = 32'h8000_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    check("midrst_out_theta", out_theta, 32'd0);
    check("midrst_out_negate", {31'b0, out_negate}, 32'd0);
    check("midrst_out_wraps", {27'b0, out_wraps}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_rel_in_ready", {31'b0, in_ready}, 32'd1);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("midrst_no_output", seen, 0);
    send("resend_m128", 32'h8000_0000, mk(32'd864684224, 1'b1, 5'd20), 1'b0);
    finish_handshake("resend_m128");

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cordic_range_reduce.md
CORDIC_RANGE_REDUCE -- requirements
Module: cordic_range_reduce

Interface
REQ-001 The block SHALL use reset rst, asynchronous, active-high; clock clk.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- in_valid  in  1  upstream angle valid
- in_ready  out  1  block can accept an angle
- in_theta  in  32  signed Q8.24 radians, range [-128, 128)
- out_valid  out  1  reduced angle valid
- out_ready  in  1  downstream CORDIC controller accepts result
- out_theta  out  32  signed Q2.30 radians, range [-pi/2, pi/2], CORDIC angle format
- out_negate  out  1  downstream SHALL negate both cos and sin
- out_wraps  out  5  number of 2*pi corrections applied
REQ-003 Constants SHALL be (name, default, meaning), all Q8.24:
- PI, 32'h03243F6B, pi
- TWO_PI, 32'h06487ED6, 2*pi
- HALF_PI, 32'h01921FB5, pi/2

Function
REQ-004 FSM states SHALL be IDLE, WRAP, FOLD, OUT.
REQ-005 in_ready SHALL be 1 only in IDLE; a transfer occurs on in_valid & in_ready.
REQ-006 On transfer, the block SHALL load acc (33-bit signed, sign-extended in_theta), clear the wrap count, and enter WRAP.
REQ-007 Each WRAP cycle SHALL apply one rule: acc > PI -> acc -= TWO_PI and count+1; acc <= -PI -> acc += TWO_PI and count+1; otherwise -> FOLD with acc unchanged.
REQ-008 WRAP SHALL leave acc in (-pi, pi]: acc == PI stays; acc == -PI becomes PI.
REQ-009 The FOLD cycle SHALL apply one rule:
- acc > HALF_PI -> acc -= PI, negate=1
- acc < -HALF_PI -> acc += PI, negate=1
- otherwise -> negate=0
After FOLD the block SHALL enter OUT.
REQ-010 FOLD SHALL treat acc == +/-HALF_PI as in range (no fold).
REQ-011 In OUT, out_valid SHALL be 1 and out_theta SHALL equal acc[25:0] shifted left 6 (exact, no rounding).
REQ-012 out_theta, out_negate and out_wraps SHALL be held stable while out_valid=1 and out_ready=0.
REQ-013 On out_valid & out_ready the block SHALL return to IDLE; in_ready SHALL be 1 in the following cycle.
REQ-014 Latency SHALL be k+2 cycles from the transfer edge to out_valid=1, where k = number of corrections (k <= 21 for the full input range).
REQ-015 in_valid SHALL be ignored outside IDLE; there is no queuing.
REQ-016 Arithmetic SHALL use 33 bits internally so no intermediate overflows.

Reset
REQ-017 Asserting rst SHALL force IDLE, acc=0, in_ready=0 while rst=1, out_valid=0, out_theta=0, out_negate=0, out_wraps=0.
REQ-018 rst in any state, including mid-WRAP, SHALL discard the pending angle with no output produced.
REQ-019 in_ready SHALL become 1 on the first clock after rst deasserts.

Verification
REQ-020 in_theta=0 -> out_theta=0, out_negate=0, out_wraps=0, out_valid 2 cycles after transfer.
REQ-021 in_theta=32'h03000000 (3.0) -> out_wraps=0, out_negate=1, out_theta=-152033984, latency 2.
REQ-022 in_theta=32'h40000000 (64.0) -> out_wraps=10, out_negate=0, out_theta=1254287616, latency 12.
REQ-023 in_theta=-32'h03243F6B (-pi) -> out_wraps=1, out_negate=1, out_theta=0.
REQ-024 Backpressure: out_ready=0 for 5 cycles with in_valid=1 throughout -> outputs stable, in_ready=0, no second transfer until the handshake completes.
REQ-025 in_theta=32'h80000000 (-128), rst pulsed after 5 WRAP cycles -> no out_valid, all outputs 0, in_ready=1 on the first clock after release; a re-sent -128 then gives out_wraps=20.
